change_dispenser: RTL and testbench

Pays out change as physical coins. Accepts a nickel count and a dime count from the refund/change calculator and drives the nickel and dime hopper solenoids one coin at a time. Each coin is confirmed by the coin-drop sensor before the next is released. Sits between the change calculator and the hopper hardware in the vending machine datapath.

---
 rtl/vend_pkg.sv | 27 ++
 rtl/dispense_timer.sv | 29 ++
 rtl/change_dispenser.sv | 153 +++++++++++++++
 tb/tb_change_dispenser.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending datapath types: dispenser states, coin kinds, coin values.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT_SENSE,
        GAP,
        DONE,
        FAULT
    } disp_state_t;

    typedef enum logic {
        COIN_NICKEL,
        COIN_DIME
    } coin_t;

    localparam int NICKEL_CENTS = 5;
    localparam int DIME_CENTS   = 10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter shared by the dispenser's pulse, gap and timeout phases.
module dispense_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // load beats clr so a state entry from a cleared state still arms the timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (clr)
            cnt <= '0;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin payout sequencer: dimes first, then nickels, one sensed coin at a time.
// Optional sensor timeout fault enabled by defining DISPENSE_TIMEOUT_EN.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int CNT_W          = 4,
    parameter int PULSE_CYCLES   = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] nickel_cnt,
    input  logic [CNT_W-1:0] dime_cnt,
    input  logic             coin_sense,
    input  logic             fault_clr,
    output logic             nickel_sol,
    output logic             dime_sol,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] nickels_left,
    output logic [CNT_W-1:0] dimes_left
);

    localparam int TMAX = max3(PULSE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);

    disp_state_t      state, state_next;
    coin_t            coin;
    logic             t_clr, t_load, t_zero;
    logic [TW-1:0]    t_val;
    logic [CNT_W-1:0] entry_dimes;
    logic             any_left;

    assign any_left    = (nickels_left != '0) || (dimes_left != '0);
    assign entry_dimes = (state == IDLE) ? dime_cnt : dimes_left;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        t_clr      = 1'b0;
        t_load     = 1'b0;
        t_val      = '0;
        unique case (state)
            IDLE: begin
                t_clr = 1'b1;
                if (start)
                    state_next = ((nickel_cnt == '0) && (dime_cnt == '0)) ? DONE : PULSE;
            end
            PULSE: begin
                if (t_zero)
                    state_next = WAIT_SENSE;
            end
            WAIT_SENSE: begin
                if (coin_sense)
                    state_next = GAP;
`ifdef DISPENSE_TIMEOUT_EN
                else if (t_zero)
                    state_next = FAULT;
`endif
            end
            GAP: begin
                if (t_zero)
                    state_next = any_left ? PULSE : DONE;
            end
            DONE: begin
                t_clr      = 1'b1;
                state_next = IDLE;
            end
            FAULT: begin
                t_clr = 1'b1;
`ifdef DISPENSE_TIMEOUT_EN
                if (fault_clr)
                    state_next = IDLE;
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
        // every state entry re-arms the shared timer for the new phase
        if (state_next != state) begin
            t_load = 1'b1;
            unique case (state_next)
                PULSE:      t_val = TW'(PULSE_CYCLES - 1);
                WAIT_SENSE: t_val = TW'(TIMEOUT_CYCLES - 1);
                GAP:        t_val = TW'(GAP_CYCLES - 1);
                default:    t_val = '0;
            endcase
        end
    end

    dispense_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (t_clr),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nickels_left <= '0;
            dimes_left   <= '0;
            coin         <= COIN_NICKEL;
        end else begin
            if (state == IDLE && start) begin
                nickels_left <= nickel_cnt;
                dimes_left   <= dime_cnt;
            end else if (state == WAIT_SENSE && coin_sense) begin
                if (coin == COIN_DIME) begin
                    if (dimes_left != '0)
                        dimes_left <= dimes_left - CNT_W'(1);
                end else if (nickels_left != '0) begin
                    nickels_left <= nickels_left - CNT_W'(1);
                end
            end
`ifdef DISPENSE_TIMEOUT_EN
            else if (state == FAULT && fault_clr) begin
                nickels_left <= '0;
                dimes_left   <= '0;
            end
`endif
            if (state != PULSE && state_next == PULSE)
                coin <= (entry_dimes != '0) ? COIN_DIME : COIN_NICKEL;
        end
    end

    assign dime_sol   = (state == PULSE) && (coin == COIN_DIME);
    assign nickel_sol = (state == PULSE) && (coin == COIN_NICKEL);
    assign busy       = (state == PULSE) || (state == WAIT_SENSE) || (state == GAP);
    assign done       = (state == DONE);

`ifdef DISPENSE_TIMEOUT_EN
    assign fault = (state == FAULT);
`else
    logic unused_fault_clr;
    assign unused_fault_clr = fault_clr;
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser against a timeline model of the payout.
module tb_change_dispenser;

    localparam int W  = 4;
    localparam int P  = 4;
    localparam int G  = 2;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] nickel_cnt;
    logic [W-1:0] dime_cnt;
    logic         coin_sense;
    logic         fault_clr;
    logic         nickel_sol;
    logic         dime_sol;
    logic         busy;
    logic         done;
    logic         fault;
    logic [W-1:0] nickels_left;
    logic [W-1:0] dimes_left;

    int errors = 0;
    int checks = 0;

    change_dispenser #(
        .CNT_W          (W),
        .PULSE_CYCLES   (P),
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .nickel_cnt   (nickel_cnt),
        .dime_cnt     (dime_cnt),
        .coin_sense   (coin_sense),
        .fault_clr    (fault_clr),
        .nickel_sol   (nickel_sol),
        .dime_sol     (dime_sol),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .nickels_left (nickels_left),
        .dimes_left   (dimes_left)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] outs();
        return {3'b0, nickel_sol, dime_sol, busy, done, fault,
                nickels_left, dimes_left};
    endfunction

    function automatic logic [15:0] pack(input bit ns, input bit ds, input bit b,
                                         input bit dn, input bit f,
                                         input int nl, input int dl);
        return {3'b0, ns, ds, b, dn, f, 4'(nl), 4'(dl)};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Coin j pulses in intervals ps[j]..ps[j]+P-1 and is sensed in interval s[j];
    // interval k is the cycle following the k-th clock edge after start is sampled.
    task automatic payout(input int n, input int d, input int maxd,
                          input int fixd, input bit junk);
        int ps[33];
        int s[32];
        int nc, dn, nl, dl;
        bit ns, ds, in_wait, sense;
        nc = n + d;
        ps[0] = 1;
        for (int j = 0; j < nc; j++) begin
            s[j] = ps[j] + P + ((fixd >= 0) ? fixd : int'($urandom_range(maxd, 0)));
            ps[j+1] = s[j] + G + 1;
        end
        dn = (nc == 0) ? 1 : s[nc-1] + G + 1;
        @(posedge clk); #1;
        start = 1'b1;
        nickel_cnt = W'(n);
        dime_cnt = W'(d);
        coin_sense = 1'b0;
        for (int k = 1; k <= dn + 1; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            coin_sense = 1'b0;
            if (junk && k <= dn && $urandom_range(3, 0) == 0) begin
                start = 1'b1;
                nickel_cnt = 4'($urandom);
                dime_cnt = 4'($urandom);
            end
            in_wait = 1'b0;
            sense = 1'b0;
            ns = 1'b0;
            ds = 1'b0;
            nl = n;
            dl = d;
            for (int j = 0; j < nc; j++) begin
                if (k >= ps[j] + P && k <= s[j]) in_wait = 1'b1;
                if (k == s[j]) sense = 1'b1;
                if (k >= ps[j] && k < ps[j] + P) begin
                    if (j < d) ds = 1'b1;
                    else ns = 1'b1;
                end
                if (s[j] < k) begin
                    if (j < d) dl--;
                    else nl--;
                end
            end
            if (sense)
                coin_sense = 1'b1;
            else if (junk && !in_wait && $urandom_range(2, 0) == 0)
                coin_sense = 1'b1;
            @(negedge clk);
            check($sformatf("pay_n%0d_d%0d_k%0d", n, d, k), outs(),
                  pack(ns, ds, (nc > 0) && (k < dn), k == dn, 1'b0, nl, dl));
        end
        coin_sense = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        nickel_cnt = '0;
        dime_cnt = '0;
        coin_sense = 1'b0;
        fault_clr = 1'b0;
        #2;
        check("reset_state", outs(), 16'h0);
        @(negedge clk);
        reset = 1'b0;

        payout(1, 2, 0, 2, 1'b0);
        payout(0, 0, 0, 0, 1'b0);
        payout(1, 2, 0, 2, 1'b1);

        @(posedge clk); #1;
        start = 1'b1;
        nickel_cnt = 4'd3;
        dime_cnt = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        check("pre_reset_sol", outs(), pack(1, 0, 1, 0, 0, 3, 0));
        reset = 1'b1;
        #1;
        check("async_reset", outs(), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        payout(3, 0, 3, -1, 1'b0);

`ifdef DISPENSE_TIMEOUT_EN
        @(posedge clk); #1;
        start = 1'b1;
        nickel_cnt = 4'd0;
        dime_cnt = 4'd1;
        for (int k = 1; k <= P + TO + 3; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (k == P + TO)
                check("to_last_wait", outs(), pack(0, 0, 1, 0, 0, 0, 1));
            else if (k > P + TO)
                check($sformatf("to_fault_k%0d", k), outs(), pack(0, 0, 0, 0, 1, 0, 1));
        end
        @(posedge clk); #1;
        fault_clr = 1'b1;
        start = 1'b1;
        dime_cnt = 4'd2;
        @(posedge clk); #1;
        fault_clr = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("to_cleared", outs(), 16'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("to_start_ignored", outs(), 16'h0);
        payout(0, 1, 0, TO - 1, 1'b1);
`else
        fault_clr = 1'b1;
        payout(0, 1, 0, 40, 1'b1);
        fault_clr = 1'b0;
`endif

        payout(15, 15, 3, -1, 1'b1);
        for (int r = 0; r < 6; r++)
            payout(int'($urandom_range(5, 0)), int'($urandom_range(5, 0)), 5, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
